branch_cond_ctrl: RTL
=====================

Name: branch_cond_ctrl

Overview:
Sequences conditional branch resolution for the core. Holds the architectural NZCV flag register and tracks flag-writing instructions that are still in flight. Accepts one branch request at a time over a valid/ready handshake and stalls it until the flags are stable. It then evaluates the 4-bit condition code and emits a one-cycle redirect with the target PC, and keeps a saturating count of taken branches.

Parameters:
ADDR_W, 32, width of PC, offset and redirect address
PEND_W, 2, width of the pending flag-write counter; maximum outstanding writes = 2^PEND_W-1
CNT_W, 16, width of the taken-branch statistics counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
flag_issue  input  1  a flag-writing instruction was issued this cycle
flag_issue_ready  output  1  pending counter below maximum; issue is legal only when high
flag_wr_valid  input  1  an ALU flag write-back occurs this cycle
flag_wr_nzcv  input  4  {negative_flag, zero_flag, carry_flag, overflow_flag} to write
br_valid  input  1  branch request valid
br_ready  output  1  block can accept a request
br_condition  input  4  condition code
br_pc  input  ADDR_W  branch instruction PC
br_offset  input  ADDR_W  signed byte offset
flush  input  1  abort the in-flight branch
resolve_valid  output  1  one-cycle resolution pulse
resolve_taken  output  1  condition result, qualified by resolve_valid
redirect_pc  output  ADDR_W  next PC, qualified by resolve_valid
flags_nzcv  output  4  current flag register
taken_count  output  CNT_W  saturating count of taken resolutions
pend_err  output  1  sticky: flag write arrived with pending==0, or issue arrived at maximum

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - flags_nzcv=0, pending=0, taken_count=0, pend_err=0.
  - resolve_valid=0, resolve_taken=0, redirect_pc=0.
  - Captured request registers are cleared.
- Flag register:
  - On flag_wr_valid, flags_nzcv takes flag_wr_nzcv at the next edge.
  - The write is always performed, including when pending==0; that case also sets pend_err.
- Pending counter, per cycle:
  - Issue only: +1.
  - Write only: -1.
  - Both together: unchanged.
  - Saturates at 0 and at maximum. An issue at maximum is dropped and sets pend_err.
  - flag_issue_ready = (pending != max).
- FSM states: IDLE, WAIT, RESOLVE.
- IDLE:
  - br_ready=1.
  - On br_valid, capture condition, pc and offset, then go to WAIT.
- WAIT:
  - br_ready=0.
  - If pending==0 this cycle, evaluate the condition against the registered flags_nzcv and go to RESOLVE.
  - A same-cycle flag write is not seen by the evaluation.
  - Otherwise stay in WAIT.
- RESOLVE:
  - resolve_valid=1 for exactly this cycle.
  - redirect_pc = taken ? pc+offset : pc+4, modulo 2^ADDR_W (wrap, no overflow flag).
  - Return to IDLE. br_ready stays 0 in this cycle.
- Minimum latency: accept at edge T, resolve_valid high in cycle T+2. Each stall cycle adds one.
- Condition codes (N,Z,C,V):
  - 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V.
  - 8 C&!Z; 9 !C|Z; 10 N==V; 11 N!=V.
  - 12 !Z&(N==V); 13 Z|(N!=V).
  - 14 always taken; 15 never taken.
- Flush:
  - In WAIT or RESOLVE: next state IDLE and the pending resolution is suppressed. resolve_valid is forced 0 in the flush cycle.
  - Flags, pending and taken_count are unaffected.
  - In IDLE, flush blocks acceptance that cycle (br_ready=0).
- taken_count increments on each resolve_valid with resolve_taken=1, and saturates at all-ones.
- Outputs are registered. resolve_taken and redirect_pc hold their last value when resolve_valid is 0.

Test Plan:
- Reset mid-WAIT with pending=2 -> all outputs 0, state IDLE, br_ready=1 on the first cycle after release.
- flags=0100 (Z=1), pending=0, cond=0, pc=0x1000, offset=0x20 -> resolve_valid two cycles after accept, taken=1, redirect_pc=0x1020; cond=1 with the same inputs -> taken=0, redirect_pc=0x1004.
- Issue two flag writers, then a branch with cond=12; write 0000 and then 1001 three cycles apart -> stays in WAIT until pending reaches 0. Evaluation uses N=1, V=1, Z=0, so taken=1.
- Simultaneous flag_issue and flag_wr_valid at pending=1 -> pending stays 1 and the branch keeps stalling. Issue at pending=3 (PEND_W=2) -> flag_issue_ready=0 and pend_err=1.
- Flush in WAIT -> no resolve_valid, back in IDLE, taken_count unchanged. cond=14 and cond=15 -> taken 1 and 0.
- pc=0xFFFFFFF0, offset=0x20, cond=14 -> redirect_pc=0x00000010. With CNT_W=2, five taken resolutions -> taken_count=3.

Source files
------------

// File: rtl/branch_cond_ctrl.sv
// Conditional branch resolver: owns the NZCV flag register, tracks in-flight flag writers,
// and stalls a single branch until flags are stable before issuing a redirect.
module branch_cond_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PEND_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_issue,
  output logic              flag_issue_ready,
  input  logic              flag_wr_valid,
  input  logic [3:0]        flag_wr_nzcv,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_condition,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              flush,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [3:0]        flags_nzcv,
  output logic [CNT_W-1:0]  taken_count,
  output logic              pend_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StResolve = 2'd2;

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [ADDR_W-1:0] InstrBytes = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic [3:0]        flags_q, flags_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              eval_taken_q, eval_taken_d;
  logic [ADDR_W-1:0] eval_pc_q, eval_pc_d;
  logic              out_taken_q, out_taken_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cond_hit;
  logic              resolving;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign cond_hit  = cond_eval(cond_q, flags_q);
  // A flush landing in the resolve cycle cancels the pulse and leaves held outputs untouched.
  assign resolving = (state_q == StResolve) && !flush;

  always_comb begin
    flags_d = flag_wr_valid ? flag_wr_nzcv : flags_q;
    err_d   = err_q | (flag_wr_valid && (pend_q == '0)) | (flag_issue && (pend_q == PendMax));
    pend_d  = pend_q;
    if (flag_issue && !flag_wr_valid && (pend_q != PendMax)) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (flag_wr_valid && !flag_issue && (pend_q != '0)) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    pc_d         = pc_q;
    off_d        = off_q;
    eval_taken_d = eval_taken_q;
    eval_pc_d    = eval_pc_q;
    out_taken_d  = out_taken_q;
    out_pc_d     = out_pc_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (br_valid && !flush) begin
          cond_d  = br_condition;
          pc_d    = br_pc;
          off_d   = br_offset;
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (pend_q == '0) begin
          eval_taken_d = cond_hit;
          eval_pc_d    = cond_hit ? (pc_q + off_q) : (pc_q + InstrBytes);
          state_d      = StResolve;
        end
      end
      StResolve: begin
        state_d = StIdle;
        if (!flush) begin
          out_taken_d = eval_taken_q;
          out_pc_d    = eval_pc_q;
          if (eval_taken_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      flags_q      <= '0;
      pend_q       <= '0;
      err_q        <= 1'b0;
      cond_q       <= '0;
      pc_q         <= '0;
      off_q        <= '0;
      eval_taken_q <= 1'b0;
      eval_pc_q    <= '0;
      out_taken_q  <= 1'b0;
      out_pc_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      cond_q       <= cond_d;
      pc_q         <= pc_d;
      off_q        <= off_d;
      eval_taken_q <= eval_taken_d;
      eval_pc_q    <= eval_pc_d;
      out_taken_q  <= out_taken_d;
      out_pc_q     <= out_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign flag_issue_ready = (pend_q != PendMax);
  assign br_ready         = (state_q == StIdle) && !flush;
  assign resolve_valid    = resolving;
  assign resolve_taken    = resolving ? eval_taken_q : out_taken_q;
  assign redirect_pc      = resolving ? eval_pc_q : out_pc_q;
  assign flags_nzcv       = flags_q;
  assign taken_count      = cnt_q;
  assign pend_err         = err_q;

endmodule
